lcd_ctrl: RTL and testbench
===========================

Name: lcd_ctrl

Overview:
- Sits directly downstream of the load-store unit and consumes its LCD output register word (o_io_lcd).
- Converts each software-issued LCD request into a correctly timed HD44780-style bus transaction: RS and data setup, EN pulse, hold, then command execution wait.
- Exposes a status word (busy and ack) that software can poll through an input port.
- Removes all LCD bus timing from firmware; software only writes a word and toggles a request bit.

Parameters:
- T_SETUP, 2, cycles RS/data are stable with EN low before the EN pulse (>=1).
- T_PW, 12, cycles EN is held high (>=1).
- T_HOLD, 2, cycles RS/data are held after EN falls (>=1).
- T_EXEC, 2000, command execution wait for normal commands and data writes (>=1).
- T_EXEC_LONG, 82000, execution wait for clear/home commands (>=1).

Ports:
- i_clk  in  1  system clock.
- i_reset  in  1  asynchronous, active-low reset.
- i_lcd_word  in  32  LCD register word from the LSU.
  - [31] ON, [30] REQ toggle, [9] RS, [7:0] DATA; all other bits ignored.
- o_lcd_data  out  8  LCD data bus.
- o_lcd_rs  out  1  register select.
- o_lcd_rw  out  1  read/write; constant 0, reads are unsupported.
- o_lcd_en  out  1  enable strobe.
- o_lcd_on  out  1  LCD power/backlight.
- o_lcd_status  out  32  status word: [31] busy, [30] ack, all other bits 0.

Behaviour:
- Reset (async assert, sync release):
  - o_lcd_data=0, o_lcd_rs=0, o_lcd_en=0, o_lcd_on=0, o_lcd_rw=0.
  - busy=0, ack=0, state IDLE, counter=0.
- o_lcd_on: registers i_lcd_word[31] every cycle (1-cycle latency), independent of the FSM.
- Request detection:
  - A request is pending when i_lcd_word[30] != ack.
  - A request is sampled only in IDLE.
- FSM states: IDLE, SETUP, PULSE, HOLD, EXEC.
- IDLE: on the edge E0 where a request is pending:
  - Latch DATA into o_lcd_data and RS into o_lcd_rs.
  - Set ack to REQ and busy to 1; go to SETUP with counter=0.
  - Latch the long flag: RS=0 and DATA[7:2]==0 and DATA!=0 (0x01, 0x02, 0x03).
- SETUP: EN=0 for T_SETUP cycles, then go to PULSE.
  - EN rises on edge E0+T_SETUP.
- PULSE: EN=1 for T_PW cycles, then go to HOLD.
  - EN falls on edge E0+T_SETUP+T_PW.
- HOLD: EN=0, data and RS unchanged for T_HOLD cycles, then go to EXEC.
- EXEC: wait T_EXEC_LONG cycles if the long flag is set, else T_EXEC.
  - Then return to IDLE and clear busy on edge E0+T_SETUP+T_PW+T_HOLD+wait.
- Output hold rules:
  - o_lcd_data and o_lcd_rs change only at acceptance; they hold their value after the transaction completes.
  - o_lcd_en is registered and glitch-free.
- Counter: one shared down- or up-counter, width $clog2(max parameter)+1.
  - Reloaded on every state change; never wraps.
- Changes to i_lcd_word while busy:
  - DATA/RS/REQ changes during SETUP..EXEC do not affect the bus.
  - The word is re-sampled only on the next IDLE acceptance.
  - If REQ toggles while busy, the request is pending and launches on the cycle after busy clears, using the word current at that edge.
  - If REQ toggles an even number of times while busy, there is no pending request and no transfer.
- Back-to-back: a pending request in IDLE is accepted on the first IDLE edge, so there is exactly one idle cycle between transactions.
- Reset mid-transaction: immediately forces EN=0, busy=0, ack=0, state IDLE.
  - After release, a word with REQ=1 is treated as pending and launches one transfer.
- o_lcd_status updates on the same edges as busy/ack; there is no combinational path from i_lcd_word.

Test Plan:
Bench parameters: T_SETUP=2, T_PW=3, T_HOLD=1, T_EXEC=5, T_EXEC_LONG=20.
1. Reset:
   - Assert i_reset=0 with i_lcd_word=0xFFFF_FFFF -> all outputs 0 and status 0x0000_0000 while reset is low.
   - Release -> o_lcd_on=1 one cycle later, then a transfer launches (REQ=1 != ack=0).
2. Data write:
   - Word 0x4000_0241 (REQ=1, RS=1, DATA=0x41) -> at E0: data=0x41, rs=1, status=0xC000_0000.
   - EN high on E0+2..E0+4, low at E0+5; busy clears at E0+11; status=0x4000_0000.
3. Clear command:
   - Toggle REQ to 0 with DATA=0x01, RS=0 -> EN pulse timing as in scenario 2.
   - busy clears at E0+26 (long wait); ack=0.
4. Toggle while busy:
   - During scenario 2's EXEC, set word 0x0000_0242 (REQ=0, DATA=0x42).
   - Bus data stays 0x41 until busy clears; the next edge accepts 0x42; EN pulses again.
5. Double toggle while busy:
   - REQ goes 1->0->1 inside one transaction -> no second transfer; busy stays 0 after completion.
6. Reset mid-pulse:
   - Assert i_reset during PULSE -> EN drops to 0 asynchronously and busy=0.
   - After release with REQ=1, exactly one fresh transfer with full SETUP timing.

Source files
------------

// File: rtl/lcd_ctrl.sv
// HD44780-style LCD bus sequencer: turns a software request toggle into a timed
// RS/data setup, EN pulse, hold and execution wait, with a pollable busy/ack status.
//
// state | meaning
// IDLE  | bus quiet, waiting for REQ != ack
// SETUP | RS/data driven, EN low
// PULSE | EN high
// HOLD  | EN low, RS/data held
// EXEC  | waiting for the LCD to execute the command
module lcd_ctrl #(
    parameter int T_SETUP     = 2,
    parameter int T_PW        = 12,
    parameter int T_HOLD      = 2,
    parameter int T_EXEC      = 2000,
    parameter int T_EXEC_LONG = 82000
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic [31:0] i_lcd_word,
    output logic [7:0]  o_lcd_data,
    output logic        o_lcd_rs,
    output logic        o_lcd_rw,
    output logic        o_lcd_en,
    output logic        o_lcd_on,
    output logic [31:0] o_lcd_status
);

    localparam int T_MAX_A = (T_SETUP > T_PW) ? T_SETUP : T_PW;
    localparam int T_MAX_B = (T_HOLD > T_EXEC) ? T_HOLD : T_EXEC;
    localparam int T_MAX_C = (T_MAX_A > T_MAX_B) ? T_MAX_A : T_MAX_B;
    localparam int T_MAX   = (T_MAX_C > T_EXEC_LONG) ? T_MAX_C : T_EXEC_LONG;
    localparam int CW      = $clog2(T_MAX) + 1;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_SETUP = 3'd1;
    localparam logic [2:0] S_PULSE = 3'd2;
    localparam logic [2:0] S_HOLD  = 3'd3;
    localparam logic [2:0] S_EXEC  = 3'd4;

    logic [2:0]    state;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_last;
    logic          busy;
    logic          ack;
    logic          long_cmd;
    logic          req_pending;
    logic          word_long;
    logic          unused_word_bits;

    assign req_pending      = (i_lcd_word[30] != ack);
    // Clear display (0x01) and return home (0x02/0x03) need the long execution wait.
    assign word_long        = !i_lcd_word[9] && (i_lcd_word[7:2] == 6'd0) && (i_lcd_word[7:0] != 8'd0);
    assign unused_word_bits = ^{i_lcd_word[29:10], i_lcd_word[8]};

    always_comb begin
        cnt_last = '0;
        case (state)
            S_SETUP: cnt_last = CW'(T_SETUP - 1);
            S_PULSE: cnt_last = CW'(T_PW - 1);
            S_HOLD:  cnt_last = CW'(T_HOLD - 1);
            S_EXEC:  cnt_last = long_cmd ? CW'(T_EXEC_LONG - 1) : CW'(T_EXEC - 1);
            default: cnt_last = '0;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state      <= S_IDLE;
            cnt        <= '0;
            busy       <= 1'b0;
            ack        <= 1'b0;
            long_cmd   <= 1'b0;
            o_lcd_data <= 8'd0;
            o_lcd_rs   <= 1'b0;
            o_lcd_en   <= 1'b0;
            o_lcd_on   <= 1'b0;
        end else begin
            o_lcd_on <= i_lcd_word[31];
            if (state == S_IDLE) begin
                if (req_pending) begin
                    o_lcd_data <= i_lcd_word[7:0];
                    o_lcd_rs   <= i_lcd_word[9];
                    ack        <= i_lcd_word[30];
                    busy       <= 1'b1;
                    long_cmd   <= word_long;
                    cnt        <= '0;
                    state      <= S_SETUP;
                end
            end else if (cnt != cnt_last) begin
                cnt <= cnt + 1'b1;
            end else begin
                cnt <= '0;
                case (state)
                    S_SETUP: begin
                        state    <= S_PULSE;
                        o_lcd_en <= 1'b1;
                    end
                    S_PULSE: begin
                        state    <= S_HOLD;
                        o_lcd_en <= 1'b0;
                    end
                    S_HOLD: state <= S_EXEC;
                    S_EXEC: begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end
                    default: begin
                        state    <= S_IDLE;
                        o_lcd_en <= 1'b0;
                        busy     <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign o_lcd_rw     = 1'b0;
    assign o_lcd_status = {busy, ack, 30'd0};

endmodule

// File: tb/tb_lcd_ctrl.sv
// Self-checking bench for lcd_ctrl: table of transfers, hand-written corner cases,
// and a randomized run compared every cycle against a transaction-timeline model.
module tb_lcd_ctrl;

    localparam int TS  = 2;
    localparam int TPW = 3;
    localparam int TH  = 1;
    localparam int TE  = 5;
    localparam int TEL = 20;

    logic        i_clk;
    logic        i_reset;
    logic [31:0] i_lcd_word;
    logic [7:0]  o_lcd_data;
    logic        o_lcd_rs;
    logic        o_lcd_rw;
    logic        o_lcd_en;
    logic        o_lcd_on;
    logic [31:0] o_lcd_status;

    lcd_ctrl #(
        .T_SETUP(TS), .T_PW(TPW), .T_HOLD(TH), .T_EXEC(TE), .T_EXEC_LONG(TEL)
    ) dut (
        .i_clk(i_clk), .i_reset(i_reset), .i_lcd_word(i_lcd_word),
        .o_lcd_data(o_lcd_data), .o_lcd_rs(o_lcd_rs), .o_lcd_rw(o_lcd_rw),
        .o_lcd_en(o_lcd_en), .o_lcd_on(o_lcd_on), .o_lcd_status(o_lcd_status)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    int n_tests = 0;
    int n_fail  = 0;
    logic chk_en = 1'b0;

    // Reference: a transfer is a timeline of t cycles since acceptance.
    logic       m_busy, m_ack, m_rs, m_long, m_on;
    logic [7:0] m_data;
    int         m_t;

    always @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            m_busy = 0; m_ack = 0; m_rs = 0; m_long = 0; m_on = 0; m_data = 0; m_t = 0;
        end else begin
            m_on = i_lcd_word[31];
            if (!m_busy) begin
                if (i_lcd_word[30] != m_ack) begin
                    m_data = i_lcd_word[7:0];
                    m_rs   = i_lcd_word[9];
                    m_ack  = i_lcd_word[30];
                    m_long = (i_lcd_word[9] == 0) && (i_lcd_word[7:0] >= 1) && (i_lcd_word[7:0] <= 3);
                    m_busy = 1;
                    m_t    = 0;
                end
            end else begin
                m_t = m_t + 1;
                if (m_t == TS + TPW + TH + (m_long ? TEL : TE)) m_busy = 0;
            end
        end
    end

    always @(posedge i_clk) begin
        logic [43:0] exp_v, act_v;
        logic        m_en;
        #1;
        if (chk_en) begin
            m_en  = m_busy && (m_t >= TS) && (m_t < TS + TPW);
            exp_v = {m_data, m_rs, 1'b0, m_en, m_on, m_busy, m_ack, 30'd0};
            act_v = {o_lcd_data, o_lcd_rs, o_lcd_rw, o_lcd_en, o_lcd_on, o_lcd_status};
            n_tests++;
            if (act_v !== exp_v) begin
                n_fail++;
                $display("FAIL model_cycle t=%0t: got %h expected %h", $time, act_v, exp_v);
            end
        end
    end

    task automatic check_int(input string name, input longint act, input longint exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Samples from transfer-relative cycle k0 onward and checks EN and busy timing.
    task automatic measure(input int k0, input int exp_total, input string name);
        int rise, fall, done;
        rise = -1; fall = -1; done = -1;
        for (int k = k0; k <= exp_total + 40 && done < 0; k++) begin
            @(posedge i_clk); #1;
            if (o_lcd_en && rise < 0) rise = k;
            if (!o_lcd_en && rise >= 0 && fall < 0) fall = k;
            if (!o_lcd_status[31]) done = k;
        end
        check_int({name, "_en_rise"}, rise, TS);
        check_int({name, "_en_fall"}, fall, TS + TPW);
        check_int({name, "_busy_clear"}, done, exp_total);
    endtask

    typedef struct {
        logic [31:0] word;
        logic [7:0]  data;
        logic        rs;
        int          total;
    } vec_t;

    vec_t vecs[11];

    initial begin
        logic req;
        logic [7:0] d;

        vecs[0]  = '{32'h0000_0001, 8'h01, 1'b0, 26};
        vecs[1]  = '{32'h4000_0241, 8'h41, 1'b1, 11};
        vecs[2]  = '{32'h0000_0002, 8'h02, 1'b0, 26};
        vecs[3]  = '{32'hC000_0003, 8'h03, 1'b0, 26};
        vecs[4]  = '{32'h0000_0000, 8'h00, 1'b0, 11};
        vecs[5]  = '{32'h4000_0204, 8'h04, 1'b1, 11};
        vecs[6]  = '{32'h0000_0004, 8'h04, 1'b0, 11};
        vecs[7]  = '{32'h4000_0201, 8'h01, 1'b1, 11};
        vecs[8]  = '{32'h8000_0080, 8'h80, 1'b0, 11};
        vecs[9]  = '{32'h4000_00FF, 8'hFF, 1'b0, 11};
        vecs[10] = '{32'h3ABC_FD41, 8'h41, 1'b0, 11};

        // Reset held with an all-ones word
        i_reset    = 1'b0;
        i_lcd_word = 32'hFFFF_FFFF;
        repeat (3) @(posedge i_clk);
        #1;
        check_int("rst_outputs", {o_lcd_data, o_lcd_rs, o_lcd_rw, o_lcd_en, o_lcd_on}, 0);
        check_int("rst_status", o_lcd_status, 32'h0000_0000);
        chk_en = 1'b1;
        @(negedge i_clk) i_reset = 1'b1;
        @(posedge i_clk); #1;
        check_int("rel_on", o_lcd_on, 1);
        check_int("rel_status", o_lcd_status, 32'hC000_0000);
        check_int("rel_data", o_lcd_data, 8'hFF);
        measure(1, 11, "rel_txn");

        // Table of single transfers
        for (int i = 0; i < 11; i++) begin
            @(negedge i_clk) i_lcd_word = vecs[i].word;
            @(posedge i_clk); #1;
            check_int($sformatf("vec%0d_data", i), o_lcd_data, vecs[i].data);
            check_int($sformatf("vec%0d_rs", i), o_lcd_rs, vecs[i].rs);
            check_int($sformatf("vec%0d_status_e0", i), o_lcd_status, {1'b1, vecs[i].word[30], 30'd0});
            measure(1, vecs[i].total, $sformatf("vec%0d", i));
            check_int($sformatf("vec%0d_status_done", i), o_lcd_status, {1'b0, vecs[i].word[30], 30'd0});
        end

        // Toggle while busy: new word waits for the current transfer
        @(negedge i_clk) i_lcd_word = 32'h4000_0241;
        @(posedge i_clk); #1;
        check_int("tog_status_e0", o_lcd_status, 32'hC000_0000);
        repeat (7) @(posedge i_clk);
        @(negedge i_clk) i_lcd_word = 32'h0000_0242;
        begin
            int done;
            done = -1;
            for (int k = 8; k <= 40 && done < 0; k++) begin
                @(posedge i_clk); #1;
                check_int($sformatf("tog_hold_data_k%0d", k), o_lcd_data, 8'h41);
                if (!o_lcd_status[31]) done = k;
            end
            check_int("tog_first_done", done, 11);
        end
        @(posedge i_clk); #1;
        check_int("tog_next_data", o_lcd_data, 8'h42);
        check_int("tog_next_status", o_lcd_status, 32'h8000_0000);
        measure(1, 11, "tog_next");

        // Double toggle while busy: no second transfer
        @(negedge i_clk) i_lcd_word = 32'h4000_0241;
        @(posedge i_clk); #1;
        check_int("dbl_status_e0", o_lcd_status, 32'hC000_0000);
        @(negedge i_clk) i_lcd_word = 32'h0000_0241;
        @(negedge i_clk) i_lcd_word = 32'h4000_0241;
        measure(2, 11, "dbl");
        begin
            int seen;
            seen = 0;
            repeat (15) begin
                @(posedge i_clk); #1;
                if (o_lcd_status[31] || o_lcd_en) seen++;
            end
            check_int("dbl_no_second", seen, 0);
        end

        // Reset in the middle of the EN pulse
        @(negedge i_clk) i_lcd_word = 32'h0000_0241;
        @(posedge i_clk); #1;
        repeat (3) @(posedge i_clk);
        #2 i_reset = 1'b0;
        #1;
        check_int("midrst_en", o_lcd_en, 0);
        check_int("midrst_status", o_lcd_status, 32'h0000_0000);
        i_lcd_word = 32'h4000_0241;
        @(negedge i_clk) i_reset = 1'b1;
        @(posedge i_clk); #1;
        check_int("midrst_relaunch_status", o_lcd_status, 32'hC000_0000);
        measure(1, 11, "midrst_txn");
        begin
            int seen;
            seen = 0;
            repeat (15) begin
                @(posedge i_clk); #1;
                if (o_lcd_status !== 32'h4000_0000 || o_lcd_en) seen++;
            end
            check_int("midrst_single", seen, 0);
        end

        // Randomized traffic against the model
        req = 1'b1;
        repeat (3000) begin
            @(negedge i_clk);
            if ($urandom_range(0, 399) == 0) begin
                i_reset = 1'b0;
                @(negedge i_clk) i_reset = 1'b1;
            end
            if ($urandom_range(0, 5) == 0) begin
                if ($urandom_range(0, 1) == 1) req = ~req;
                d = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 3)) : 8'($urandom);
                i_lcd_word = {1'($urandom), req, 20'($urandom), 1'($urandom), 1'($urandom), d};
            end
        end

        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
